// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared op codes, lane slicing and saturation bounds for the SIMD add/sub pipe
package simd_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  // Widest packed vector and widest lane the unit is ever built with.
  localparam int MAX_VEC_W  = 48;
  localparam int MAX_LANE_W = 24;

  // Lane i of a vector left-aligned in MAX_VEC_W bits, lane 0 in the MSBs.
  function automatic logic [MAX_LANE_W-1:0] lane_slice(input logic [MAX_VEC_W-1:0] vec,
                                                       input int i, input int W);
    logic [MAX_VEC_W-1:0] t;
    t = vec << (i * W);
    t = t >> (MAX_VEC_W - W);
    return t[MAX_LANE_W-1:0];
  endfunction

  // Largest positive two's-complement value of a W-bit lane (0111..1).
  function automatic logic [MAX_LANE_W-1:0] sat_hi(input int W);
    logic [MAX_LANE_W-1:0] v;
    v = '0;
    for (int k = 0; k < W - 1; k++) v[k] = 1'b1;
    return v;
  endfunction

  // Most negative two's-complement value of a W-bit lane (1000..0).
  function automatic logic [MAX_LANE_W-1:0] sat_lo(input int W);
    logic [MAX_LANE_W-1:0] v;
    v = '0;
    v[W-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// rtl/simd_lane_alu.sv - one combinational lane: add/sub/acc/load with overflow flag and optional clamp
module simd_lane_alu import simd_pkg::*; #(
  parameter int LANE_W = 12
) (
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  logic [LANE_W-1:0] acc_i,
  input  op_e               op,
  input  logic              sat_en,
  output logic [LANE_W-1:0] result_i,
  output logic              ovf_i
);

  localparam logic [LANE_W-1:0] SAT_HI = LANE_W'(sat_hi(LANE_W));
  localparam logic [LANE_W-1:0] SAT_LO = LANE_W'(sat_lo(LANE_W));

  // One guard bit is enough: the sum or difference of two W-bit values fits in W+1 bits.
  logic signed [LANE_W:0] a_x, b_x, acc_x, r;

  assign a_x   = {a_i[LANE_W-1], a_i};
  assign b_x   = {b_i[LANE_W-1], b_i};
  assign acc_x = {acc_i[LANE_W-1], acc_i};

  // Raw lane result in W+1-bit signed arithmetic.
  always_comb begin
    r = a_x;
    case (op)
      OP_ADD:  r = a_x + b_x;
      OP_SUB:  r = a_x - b_x;
      OP_ACC:  r = acc_x + a_x;
      OP_LOAD: r = a_x;
      default: r = a_x;
    endcase
  end

  // Out of range exactly when the guard bit disagrees with the lane sign bit; the guard bit is the true sign.
  always_comb begin
    ovf_i    = r[LANE_W] ^ r[LANE_W-1];
    result_i = r[LANE_W-1:0];
    if (ovf_i && sat_en) begin
      result_i = r[LANE_W] ? SAT_LO : SAT_HI;
    end
  end

endmodule

// File: rtl/simd_addsub_pipe.sv
// rtl/simd_addsub_pipe.sv - parametrised pipelined SIMD add/sub/accumulate unit with clock-enable stall
module simd_addsub_pipe import simd_pkg::*; #(
  parameter int LANES  = 4,
  parameter int LANE_W = 12,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    in_valid,
  input  logic [1:0]              op,
  input  logic                    sat_en,
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  output logic                    out_valid,
  output logic [LANES*LANE_W-1:0] ap_return,
  output logic [LANES-1:0]        ovf
);

  localparam int DW = LANES * LANE_W;

  // Stage 1: registered inputs.
  logic          v1_q;
  op_e           op1_q;
  logic          sat1_q;
  logic [DW-1:0] a1_q, b1_q;

  // Stage 2..STAGES: result, flags and valid; index STAGES drives the outputs.
  logic          vld_q [2:STAGES];
  logic [DW-1:0] res_q [2:STAGES];
  logic [LANES-1:0] ovf_q [2:STAGES];

  logic [LANE_W-1:0] acc_q    [LANES];
  logic [LANE_W-1:0] lane_res [LANES];
  logic              lane_ovf [LANES];

  logic [DW-1:0]        res_d;
  logic [LANES-1:0]     ovf_d;
  logic [MAX_VEC_W-1:0] a_al, b_al;
  logic                 acc_we;

  // Capture the input beat on every enabled cycle; reset empties the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      op1_q  <= OP_ADD;
      sat1_q <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
    end else if (ce) begin
      v1_q   <= in_valid;
      op1_q  <= op_e'(op);
      sat1_q <= sat_en;
      a1_q   <= a;
      b1_q   <= b;
    end
  end

  // Left-align the operands so lane_slice can address lanes MSB-first for any LANES*LANE_W.
  assign a_al = MAX_VEC_W'(a1_q) << (MAX_VEC_W - DW);
  assign b_al = MAX_VEC_W'(b1_q) << (MAX_VEC_W - DW);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] a_l, b_l;

    assign a_l = LANE_W'(lane_slice(a_al, i, LANE_W));
    assign b_l = LANE_W'(lane_slice(b_al, i, LANE_W));

    simd_lane_alu #(.LANE_W(LANE_W)) u_alu (
      .a_i      (a_l),
      .b_i      (b_l),
      .acc_i    (acc_q[i]),
      .op       (op1_q),
      .sat_en   (sat1_q),
      .result_i (lane_res[i]),
      .ovf_i    (lane_ovf[i])
    );

    assign res_d[(LANES-1-i)*LANE_W +: LANE_W] = lane_res[i];
    assign ovf_d[LANES-1-i]                    = lane_ovf[i];
  end

  // Only valid ACC/LOAD beats touch the accumulators; ADD/SUB and bubbles leave them alone.
  assign acc_we = v1_q && ((op1_q == OP_ACC) || (op1_q == OP_LOAD));

  // Accumulators take the final lane result in the same edge that registers it, so back-to-back ACC needs no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
    end else if (ce && acc_we) begin
      for (int k = 0; k < LANES; k++) acc_q[k] <= lane_res[k];
    end
  end

  // Compute register followed by pure delay stages, all frozen together when ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 2; k <= STAGES; k++) begin
        vld_q[k] <= 1'b0;
        res_q[k] <= '0;
        ovf_q[k] <= '0;
      end
    end else if (ce) begin
      vld_q[2] <= v1_q;
      res_q[2] <= res_d;
      ovf_q[2] <= ovf_d;
      for (int k = 3; k <= STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        res_q[k] <= res_q[k-1];
        ovf_q[k] <= ovf_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES];
  assign ap_return = res_q[STAGES];
  assign ovf       = ovf_q[STAGES];

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// tb/tb_simd_addsub_pipe.sv - scoreboard bench for simd_addsub_pipe at 4x12/2 stages and 2x24/4 stages
module tb_simd_addsub_pipe;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, ce = 1'b0;
  logic        iv   [2];
  logic [1:0]  opv  [2];
  logic        satv [2];
  logic [47:0] av   [2];
  logic [47:0] bv   [2];
  logic        ovl  [2];
  logic [47:0] ret  [2];
  logic [3:0]  ovf0;
  logic [1:0]  ovf1;

  simd_addsub_pipe #(.LANES(4), .LANE_W(12), .STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv[0]), .op(opv[0]), .sat_en(satv[0]),
    .a(av[0]), .b(bv[0]), .out_valid(ovl[0]), .ap_return(ret[0]), .ovf(ovf0));

  simd_addsub_pipe #(.LANES(2), .LANE_W(24), .STAGES(4)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv[1]), .op(opv[1]), .sat_en(satv[1]),
    .a(av[1]), .b(bv[1]), .out_valid(ovl[1]), .ap_return(ret[1]), .ovf(ovf1));

  typedef struct {
    logic [47:0] res;
    logic [7:0]  ov;
    int          en;
  } exp_t;

  exp_t   sbq [2][$];
  longint macc [2][8];
  int     checks = 0, errors = 0, en_cnt = 0;
  bit          use_exp = 1'b0;
  logic [47:0] exp_res;
  logic [7:0]  exp_ov;

  function automatic int lanes_of(int k); return (k == 0) ? 4 : 2; endfunction
  function automatic int width_of(int k); return (k == 0) ? 12 : 24; endfunction
  function automatic int stages_of(int k); return (k == 0) ? 2 : 4; endfunction

  function automatic longint sx(longint x, int w);
    return (x >= (64'sd1 <<< (w - 1))) ? x - (64'sd1 <<< w) : x;
  endfunction

  // Reference: per-lane integer arithmetic, range test, clamp or wrap, accumulator update.
  function automatic void model(input int k, input logic [1:0] o, input bit s,
                                input logic [47:0] a_v, input logic [47:0] b_v,
                                output logic [47:0] res, output logic [7:0] ov);
    int L, W, pos;
    longint m, hi, lo, ai, bi, r, f;
    L = lanes_of(k);
    W = width_of(k);
    m  = (64'sd1 <<< W) - 1;
    hi = (64'sd1 <<< (W - 1)) - 1;
    lo = -(64'sd1 <<< (W - 1));
    res = '0;
    ov  = '0;
    for (int i = 0; i < L; i++) begin
      pos = (L - 1 - i) * W;
      ai = sx(longint'(a_v >> pos) & m, W);
      bi = sx(longint'(b_v >> pos) & m, W);
      case (o)
        ADD:     r = ai + bi;
        SUB:     r = ai - bi;
        ACC:     r = macc[k][i] + ai;
        default: r = ai;
      endcase
      if (s) f = (r > hi) ? hi : ((r < lo) ? lo : r);
      else   f = sx(r & m, W);
      ov[L-1-i] = (r > hi) || (r < lo);
      res = res | (48'(f & m) << pos);
      if (o == ACC || o == LOAD) macc[k][i] = f;
    end
  endfunction

  function automatic logic [47:0] rand_vec(int k);
    int L, W;
    longint x, m;
    logic [47:0] v;
    L = lanes_of(k);
    W = width_of(k);
    m = (64'sd1 <<< W) - 1;
    v = '0;
    for (int i = 0; i < L; i++) begin
      case ($urandom % 5)
        0:       x = (64'sd1 <<< (W - 1)) - 1;
        1:       x = 64'sd1 <<< (W - 1);
        2:       x = m;
        default: x = longint'($urandom) & m;
      endcase
      v = v | (48'(x) << (i * W));
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Record expectations for every beat the DUTs will accept at the coming edge.
  task automatic accept();
    exp_t e;
    logic [47:0] r_m;
    logic [7:0]  o_m;
    for (int k = 0; k < 2; k++) begin
      if (ce && !rst && iv[k]) begin
        model(k, opv[k], satv[k], av[k], bv[k], r_m, o_m);
        e.res = r_m;
        e.ov  = o_m;
        if (k == 0 && use_exp) begin
          e.res = exp_res;
          e.ov  = exp_ov;
        end
        e.en = en_cnt + 1;
        sbq[k].push_back(e);
      end
    end
    use_exp = 1'b0;
  endtask

  task automatic go(input bit c, input bit r, input bit v, input logic [1:0] o, input bit s,
                    input logic [47:0] a_v, input logic [47:0] b_v);
    @(negedge clk);
    ce = c; rst = r;
    iv[0] = v; opv[0] = o; satv[0] = s; av[0] = a_v; bv[0] = b_v;
    iv[1] = 1'b0;
    accept();
  endtask

  task automatic idle(input int n);
    repeat (n) go(1'b1, 1'b0, 1'b0, ADD, 1'b0, '0, '0);
  endtask

  task automatic dir(input logic [1:0] o, input bit s, input logic [47:0] a_v,
                     input logic [47:0] b_v, input logic [47:0] er, input logic [7:0] eo);
    use_exp = 1'b1;
    exp_res = er;
    exp_ov  = eo;
    go(1'b1, 1'b0, 1'b1, o, s, a_v, b_v);
  endtask

  // Monitor: an output beat is presented after each enabled edge with out_valid high.
  initial begin : mon
    bit   upd;
    exp_t e;
    forever begin
      @(posedge clk);
      upd = ce && !rst;
      if (rst) begin
        for (int k = 0; k < 2; k++) sbq[k].delete();
        foreach (macc[k, i]) macc[k][i] = 0;
      end
      if (upd) en_cnt++;
      @(negedge clk);
      if (upd) begin
        for (int k = 0; k < 2; k++) begin
          if (ovl[k]) begin
            if (sbq[k].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out%0d actual=out_valid 1 required=no beat pending", k);
            end else begin
              e = sbq[k].pop_front();
              chk($sformatf("ret%0d", k), ret[k], e.res);
              chk($sformatf("ovf%0d", k), (k == 0) ? {60'd0, ovf0} : {62'd0, ovf1}, e.ov);
              chk($sformatf("latency%0d", k), en_cnt - e.en, stages_of(k) - 1);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; opv[k] = ADD; satv[k] = 1'b0; av[k] = '0; bv[k] = '0;
    end

    // Reset with ce low must still clear everything.
    go(1'b0, 1'b1, 1'b0, ADD, 1'b0, '0, '0);
    go(1'b0, 1'b1, 1'b0, ADD, 1'b0, '0, '0);
    idle(1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), ovl[k], 0);
      chk($sformatf("rst_ret%0d", k), ret[k], 0);
    end
    chk("rst_ovf0", ovf0, 0);
    chk("rst_ovf1", ovf1, 0);

    // Lane isolation, wrap and saturation.
    dir(ADD, 1'b0, 48'h7FF000FFF001, 48'h0010000017FF, 48'h800000000800, 8'h09);
    dir(ADD, 1'b1, 48'h7FF000FFF001, 48'h0010000017FF, 48'h7FF0000007FF, 8'h09);
    dir(SUB, 1'b1, 48'h800800800800, 48'h001001001001, 48'h800800800800, 8'h0F);

    // Load then back-to-back accumulates, then saturating accumulate holds at max.
    dir(LOAD, 1'b0, 48'h005005005005, '0, 48'h005005005005, 8'h00);
    dir(ACC,  1'b0, 48'h003003003003, '0, 48'h008008008008, 8'h00);
    dir(ACC,  1'b0, 48'h003003003003, '0, 48'h00B00B00B00B, 8'h00);
    dir(ACC,  1'b0, 48'h003003003003, '0, 48'h00E00E00E00E, 8'h00);
    dir(ACC,  1'b1, 48'h7FF7FF7FF7FF, '0, 48'h7FF7FF7FF7FF, 8'h0F);
    dir(ACC,  1'b1, 48'h7FF7FF7FF7FF, '0, 48'h7FF7FF7FF7FF, 8'h0F);
    idle(4);

    // CE stall mid-pipeline; a beat offered while ce is low is dropped.
    dir(LOAD, 1'b0, 48'h001001001001, '0, 48'h001001001001, 8'h00);
    go(1'b0, 1'b0, 1'b0, ADD, 1'b0, '0, '0);
    go(1'b0, 1'b0, 1'b1, ACC, 1'b0, 48'h00F00F00F00F, '0);
    go(1'b0, 1'b0, 1'b0, ADD, 1'b0, '0, '0);
    dir(ACC, 1'b0, 48'h001001001001, '0, 48'h002002002002, 8'h00);
    chk("stall_hold_valid", ovl[0], 0);
    idle(5);

    // Reset with beats in flight discards them and clears the accumulators.
    dir(LOAD, 1'b0, 48'h00A00A00A00A, '0, 48'h00A00A00A00A, 8'h00);
    dir(ACC,  1'b0, 48'h001001001001, '0, 48'h00B00B00B00B, 8'h00);
    go(1'b1, 1'b1, 1'b0, ADD, 1'b0, '0, '0);
    idle(1);
    chk("midrst_valid", ovl[0], 0);
    chk("midrst_ret", ret[0], 0);
    idle(2);
    chk("midrst_valid_late", ovl[0], 0);
    dir(ACC, 1'b0, 48'h001001001001, '0, 48'h001001001001, 8'h00);
    idle(4);

    // Random traffic on both configurations against the reference model.
    repeat (600) begin
      @(negedge clk);
      ce  = ($urandom % 10) != 0;
      rst = ($urandom % 60) == 0;
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom % 10) < 7;
        opv[k]  = 2'($urandom % 4);
        satv[k] = 1'($urandom % 2);
        av[k]   = rand_vec(k);
        bv[k]   = rand_vec(k);
      end
      accept();
    end

    // Drain both pipelines; nothing may remain outstanding.
    @(negedge clk);
    ce = 1'b1; rst = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("drain0", sbq[0].size(), 0);
    chk("drain1", sbq[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
